// File: rtl/sram_ctrl_pkg.sv
// sram_ctrl_pkg: shared states, widths and address helper for the SRAM controller
package sram_ctrl_pkg;

    typedef enum logic [2:0] {IDLE, SETUP, ACCESS, HOLD, ACK} sram_state_t;

    localparam int SRAM_WAIT_W = 4;

    function automatic int sram_saw(input int aw, input int dw);
        return aw - $clog2(dw / 8);
    endfunction

endpackage

// File: rtl/sram_wait_cnt.sv
// sram_wait_cnt: loadable down-counter timing the SRAM ACCESS phase
module sram_wait_cnt
    import sram_ctrl_pkg::*;
(
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_load,
    input  logic [SRAM_WAIT_W-1:0] i_val,
    input  logic                   i_dec,
    output logic [SRAM_WAIT_W-1:0] o_val,
    output logic                   o_zero
);

    logic [SRAM_WAIT_W-1:0] r_cnt;

    // load wins over decrement; the count parks at zero
    always_ff @(posedge i_clk or posedge i_rst)
        if (i_rst) r_cnt <= '0;
        else if (i_load) r_cnt <= i_val;
        else if (i_dec && r_cnt != '0) r_cnt <= r_cnt - 1'b1;

    assign o_val  = r_cnt;
    assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/sram_ctrl.sv
// sram_ctrl: Wishbone slave for async SRAM; define SRAM_CTRL_WE_HOLD_EN to add a write data-hold state
module sram_ctrl
    import sram_ctrl_pkg::*;
#(
    parameter  int AWIDTH  = 20,
    parameter  int SRAM_DW = 32,
    parameter  int RD_WAIT = 1,
    parameter  int WR_WAIT = 1,
    localparam int SAW     = sram_saw(AWIDTH, SRAM_DW),
    localparam int BW      = SRAM_DW / 8
)(
    input  logic               wb_clk_i,
    input  logic               wb_rst_i,
    input  logic [AWIDTH-1:0]  wb_adr_i,
    input  logic [31:0]        wb_dat_i,
    output logic [31:0]        wb_dat_o,
    input  logic [3:0]         wb_sel_i,
    input  logic               wb_we_i,
    input  logic               wb_cyc_i,
    input  logic               wb_stb_i,
    output logic               wb_ack_o,
    input  logic [SRAM_DW-1:0] sram_dat_i,
    output logic [SRAM_DW-1:0] sram_dat_o,
    output logic               sram_dat_oe_o,
    output logic [SAW-1:0]     sram_addr_o,
    output logic [BW-1:0]      sram_nbe_o,
    output logic               sram_ncs_o,
    output logic               sram_noe_o,
    output logic               sram_nwe_o
);

    localparam logic [SRAM_WAIT_W-1:0] L_RD = SRAM_WAIT_W'(RD_WAIT);
    localparam logic [SRAM_WAIT_W-1:0] L_WR = SRAM_WAIT_W'(WR_WAIT);

    sram_state_t r_state, w_nxt, w_done;

    logic [AWIDTH-1:2]      r_adr, w_adr_n;
    logic [31:0]            r_wdat, w_dat_n, r_rdata, w_mask, w_cap;
    logic [3:0]             r_sel, w_sel_n;
    logic                   r_we, r_half, r_pend, r_abort;
    logic                   w_acc, w_we_n, w_half_n, w_act_n, w_last, w_first, w_pend, w_zero;
    logic                   r_ncs, r_noe, r_nwe, r_oe, r_ack;
    logic [BW-1:0]          r_nbe, w_nbe_n;
    logic [SAW-1:0]         r_addr, w_addr_n;
    logic [SRAM_DW-1:0]     r_sdo, w_wd_n;
    logic [SRAM_WAIT_W-1:0] w_cnt;
    logic                   w_unused;

    sram_wait_cnt u_wait (
        .i_clk  (wb_clk_i),
        .i_rst  (wb_rst_i),
        .i_load (r_state == SETUP),
        .i_val  (r_we ? L_WR : L_RD),
        .i_dec  (r_state == ACCESS),
        .o_val  (w_cnt),
        .o_zero (w_zero)
    );

    // next state: a started half always runs to the end, abort only skips what follows
    always_comb begin
        w_done = ACK;
        if (r_pend) w_done = SETUP;
        if (r_abort || !wb_cyc_i) w_done = IDLE;
        w_nxt = r_state;
        case (r_state)
            IDLE:    if (wb_cyc_i && wb_stb_i && !r_ack) w_nxt = SETUP;
            SETUP:   w_nxt = ACCESS;
`ifdef SRAM_CTRL_WE_HOLD_EN
            ACCESS:  if (w_zero) w_nxt = r_we ? HOLD : w_done;
`else
            ACCESS:  if (w_zero) w_nxt = w_done;
`endif
            HOLD:    w_nxt = w_done;
            ACK:     w_nxt = IDLE;
            default: w_nxt = IDLE;
        endcase
    end

    assign w_acc    = (r_state == IDLE) && (w_nxt == SETUP);
    assign w_adr_n  = w_acc ? wb_adr_i[AWIDTH-1:2] : r_adr;
    assign w_dat_n  = w_acc ? wb_dat_i : r_wdat;
    assign w_sel_n  = w_acc ? wb_sel_i : r_sel;
    assign w_we_n   = w_acc ? wb_we_i : r_we;
    assign w_half_n = w_acc ? w_first : ((w_nxt == SETUP) ? 1'b1 : r_half);
    assign w_act_n  = (w_nxt == SETUP) || (w_nxt == ACCESS) || (w_nxt == HOLD);
    assign w_last   = (r_state == ACCESS) && w_zero;
    assign w_mask   = {{8{r_sel[3]}}, {8{r_sel[2]}}, {8{r_sel[1]}}, {8{r_sel[0]}}};

    generate
        if (SRAM_DW == 32) begin : g_w32
            assign w_first  = 1'b0;
            assign w_pend   = 1'b0;
            assign w_nbe_n  = ~w_sel_n;
            assign w_addr_n = w_adr_n;
            assign w_wd_n   = w_dat_n;
            assign w_cap    = sram_dat_i & w_mask;
            assign w_unused = ^{wb_adr_i[1:0], w_cnt, w_half_n};
        end else begin : g_w16
            assign w_first  = (wb_sel_i[3:2] == 2'b00) && (wb_sel_i[1:0] != 2'b00);
            assign w_pend   = (wb_sel_i[3:2] != 2'b00) && (wb_sel_i[1:0] != 2'b00);
            assign w_nbe_n  = w_half_n ? ~w_sel_n[1:0] : ~w_sel_n[3:2];
            assign w_addr_n = {w_adr_n, w_half_n};
            assign w_wd_n   = w_half_n ? w_dat_n[15:0] : w_dat_n[31:16];
            assign w_cap    = r_half ? {r_rdata[31:16], sram_dat_i & w_mask[15:0]}
                                     : {sram_dat_i & w_mask[31:16], r_rdata[15:0]};
            assign w_unused = ^{wb_adr_i[1:0], w_cnt};
        end
    endgenerate

    // FSM state plus the request latched at acceptance
    always_ff @(posedge wb_clk_i or posedge wb_rst_i)
        if (wb_rst_i) begin
            r_state <= IDLE;
            r_adr   <= '0;
            r_wdat  <= '0;
            r_sel   <= '0;
            r_we    <= 1'b0;
            r_half  <= 1'b0;
            r_pend  <= 1'b0;
            r_abort <= 1'b0;
        end else begin
            r_state <= w_nxt;
            r_adr   <= w_adr_n;
            r_wdat  <= w_dat_n;
            r_sel   <= w_sel_n;
            r_we    <= w_we_n;
            r_half  <= w_half_n;
            r_pend  <= w_acc ? w_pend : ((w_nxt == SETUP) ? 1'b0 : r_pend);
            r_abort <= w_acc ? 1'b0 : (r_abort || (r_state != IDLE && !wb_cyc_i));
        end

    // pins are registered from the next state so every strobe is glitch-free
    always_ff @(posedge wb_clk_i or posedge wb_rst_i)
        if (wb_rst_i) begin
            r_ncs   <= 1'b1;
            r_noe   <= 1'b1;
            r_nwe   <= 1'b1;
            r_nbe   <= '1;
            r_oe    <= 1'b0;
            r_ack   <= 1'b0;
            r_addr  <= '0;
            r_sdo   <= '0;
            r_rdata <= '0;
        end else begin
            r_ncs   <= !w_act_n;
            r_noe   <= !(w_act_n && !w_we_n);
            r_nwe   <= !((w_nxt == ACCESS) && w_we_n);
            r_nbe   <= w_act_n ? w_nbe_n : '1;
            r_oe    <= w_act_n && w_we_n;
            r_ack   <= (w_nxt == ACK);
            r_addr  <= w_act_n ? w_addr_n : r_addr;
            r_sdo   <= (w_act_n && w_we_n) ? w_wd_n : r_sdo;
            r_rdata <= w_acc ? '0 : ((w_last && !r_we) ? w_cap : r_rdata);
        end

    assign wb_dat_o      = r_rdata;
    assign wb_ack_o      = r_ack;
    assign sram_dat_o    = r_sdo;
    assign sram_dat_oe_o = r_oe;
    assign sram_addr_o   = r_addr;
    assign sram_nbe_o    = r_nbe;
    assign sram_ncs_o    = r_ncs;
    assign sram_noe_o    = r_noe;
    assign sram_nwe_o    = r_nwe;

endmodule

// File: tb/tb_sram_ctrl.sv
// tb_sram_ctrl: randomized bench for a 32-bit and a 16-bit sram_ctrl against a byte-level memory model
module tb_sram_ctrl;

`ifdef SRAM_CTRL_WE_HOLD_EN
    localparam int HOLD = 1;
`else
    localparam int HOLD = 0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [19:0] adr [2];
    logic [31:0] wdat [2];
    logic [31:0] rdat [2];
    logic [3:0]  sel [2];
    logic        we [2], cyc [2], stb [2], ack [2];
    logic        oe [2], ncs [2], noe [2], nwe [2];
    logic [31:0] sdi0, sdo0;
    logic [17:0] sa0;
    logic [3:0]  nbe0;
    logic [15:0] sdi1, sdo1;
    logic [18:0] sa1;
    logic [1:0]  nbe1;
    logic [31:0] mem0 [256];
    logic [15:0] mem1 [512];
    logic [7:0]  refm [2][1024];
    int          n_chk = 0;
    int          n_err = 0;

    always #5 clk = ~clk;

    sram_ctrl #(.AWIDTH(20), .SRAM_DW(32), .RD_WAIT(1), .WR_WAIT(2)) u_dut0 (
        .wb_clk_i(clk), .wb_rst_i(rst), .wb_adr_i(adr[0]), .wb_dat_i(wdat[0]), .wb_dat_o(rdat[0]),
        .wb_sel_i(sel[0]), .wb_we_i(we[0]), .wb_cyc_i(cyc[0]), .wb_stb_i(stb[0]), .wb_ack_o(ack[0]),
        .sram_dat_i(sdi0), .sram_dat_o(sdo0), .sram_dat_oe_o(oe[0]), .sram_addr_o(sa0),
        .sram_nbe_o(nbe0), .sram_ncs_o(ncs[0]), .sram_noe_o(noe[0]), .sram_nwe_o(nwe[0])
    );

    sram_ctrl #(.AWIDTH(20), .SRAM_DW(16), .RD_WAIT(0), .WR_WAIT(1)) u_dut1 (
        .wb_clk_i(clk), .wb_rst_i(rst), .wb_adr_i(adr[1]), .wb_dat_i(wdat[1]), .wb_dat_o(rdat[1]),
        .wb_sel_i(sel[1]), .wb_we_i(we[1]), .wb_cyc_i(cyc[1]), .wb_stb_i(stb[1]), .wb_ack_o(ack[1]),
        .sram_dat_i(sdi1), .sram_dat_o(sdo1), .sram_dat_oe_o(oe[1]), .sram_addr_o(sa1),
        .sram_nbe_o(nbe1), .sram_ncs_o(ncs[1]), .sram_noe_o(noe[1]), .sram_nwe_o(nwe[1])
    );

    // async SRAM pin models; reads return junk unless chip and output are enabled
    assign sdi0 = (!ncs[0] && !noe[0]) ? mem0[sa0[7:0]] : 32'hDEADBEEF;
    assign sdi1 = (!ncs[1] && !noe[1]) ? mem1[sa1[8:0]] : 16'hBEEF;

    // a write lands on every clock edge that sees nCS and nWE low
    always @(posedge clk) begin
        for (int i = 0; i < 4; i++)
            if (!ncs[0] && !nwe[0] && !nbe0[i]) mem0[sa0[7:0]][8*i +: 8] <= sdo0[8*i +: 8];
        for (int i = 0; i < 2; i++)
            if (!ncs[1] && !nwe[1] && !nbe1[i]) mem1[sa1[8:0]][8*i +: 8] <= sdo1[8*i +: 8];
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not end, got timeout required finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] addr_of(input int d);
        return d == 0 ? {14'b0, sa0} : {13'b0, sa1};
    endfunction

    function automatic logic [31:0] nbe_of(input int d);
        return d == 0 ? {28'b0, nbe0} : {30'b0, nbe1};
    endfunction

    task automatic xfer(input int d, input bit w, input logic [19:0] a, input logic [31:0] wd, input logic [3:0] s);
        int          hi, lo, halves, wt, hold, base, ack_k, starts, ncs_c, noe_c, nwe_c, nwe_f, oe_c;
        logic [31:0] exp_d, got_d, fa, la, pa, fnbe, efa, ela, enbe;
        logic [3:0]  ns;
        bit          pn, pw, first_lo;
        hi       = int'(s[3:2] != 2'b00);
        lo       = int'(s[1:0] != 2'b00);
        halves   = (d == 0 || hi + lo == 0) ? 1 : hi + lo;
        wt       = w ? (d == 0 ? 2 : 1) : (d == 0 ? 1 : 0);
        hold     = w ? HOLD : 0;
        base     = int'(a[9:2]) * 4;
        first_lo = (hi == 0) && (lo == 1);
        ns       = ~s;
        exp_d    = '0;
        for (int i = 0; i < 4; i++) if (s[i]) exp_d[8*i +: 8] = refm[d][base + 3 - i];
        efa  = d == 0 ? {14'b0, a[19:2]} : {13'b0, a[19:2], first_lo};
        ela  = (halves == 2) ? {13'b0, a[19:2], 1'b1} : efa;
        enbe = d == 0 ? {28'b0, ns} : {30'b0, (first_lo ? ns[1:0] : ns[3:2])};
        @(negedge clk);
        adr[d] = a; wdat[d] = wd; sel[d] = s; we[d] = w; cyc[d] = 1'b1; stb[d] = 1'b1;
        ack_k = 0; starts = 0; ncs_c = 0; noe_c = 0; nwe_c = 0; nwe_f = 0; oe_c = 0;
        pn = 1'b1; pw = 1'b1; pa = '1; fa = '1; la = '1; fnbe = '1; got_d = '0;
        for (int k = 1; k <= 100 && ack_k == 0; k++) begin
            @(negedge clk);
            if (!ncs[d]) begin
                ncs_c++;
                if (pn || addr_of(d) != pa) begin
                    starts++;
                    if (starts == 1) begin fa = addr_of(d); fnbe = nbe_of(d); end
                    la = addr_of(d);
                end
            end
            if (!noe[d]) noe_c++;
            if (!nwe[d]) nwe_c++;
            if (pw && !nwe[d]) nwe_f++;
            if (oe[d]) oe_c++;
            pn = ncs[d]; pw = nwe[d]; pa = addr_of(d);
            if (ack[d]) begin
                ack_k = k;
                got_d = rdat[d];
            end else begin
                stb[d] = 1'($urandom_range(0, 1));
                adr[d] = 20'($urandom); wdat[d] = $urandom; sel[d] = 4'($urandom); we[d] = 1'($urandom);
            end
        end
        cyc[d] = 1'b0; stb[d] = 1'b0; we[d] = 1'b0;
        check($sformatf("d%0d ack_cycle", d), ack_k, halves * (wt + 2 + hold) + 1);
        check($sformatf("d%0d sram_cycles", d), starts, halves);
        check($sformatf("d%0d ncs_low", d), ncs_c, halves * (wt + 2 + hold));
        check($sformatf("d%0d noe_low", d), noe_c, w ? 0 : halves * (wt + 2));
        check($sformatf("d%0d nwe_low", d), nwe_c, w ? halves * (wt + 1) : 0);
        check($sformatf("d%0d nwe_falls", d), nwe_f, w ? halves : 0);
        check($sformatf("d%0d oe_high", d), oe_c, w ? halves * (wt + 2 + hold) : 0);
        check($sformatf("d%0d first_addr", d), fa, efa);
        check($sformatf("d%0d last_addr", d), la, ela);
        check($sformatf("d%0d first_nbe", d), fnbe, enbe);
        if (!w) check($sformatf("d%0d rdata", d), got_d, exp_d);
        if (w) for (int i = 0; i < 4; i++) if (s[i]) refm[d][base + 3 - i] = wd[8*i +: 8];
    endtask

    initial begin
        int acks, starts, nwe_c;
        bit pn;
        logic [31:0] pa;
        for (int d = 0; d < 2; d++) begin
            adr[d] = '0; wdat[d] = '0; sel[d] = '0; we[d] = 1'b0; cyc[d] = 1'b0; stb[d] = 1'b0;
            for (int b = 0; b < 1024; b++) refm[d][b] = 8'($urandom);
        end
        refm[0][20] = 8'h11; refm[0][21] = 8'h22; refm[0][22] = 8'h33; refm[0][23] = 8'h44;
        refm[1][16] = 8'h12; refm[1][17] = 8'h34; refm[1][18] = 8'h56; refm[1][19] = 8'h78;
        for (int i = 0; i < 256; i++) mem0[i] = {refm[0][4*i], refm[0][4*i+1], refm[0][4*i+2], refm[0][4*i+3]};
        for (int i = 0; i < 512; i++) mem1[i] = {refm[1][2*i], refm[1][2*i+1]};
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            check($sformatf("d%0d rst_strobes", d), {27'b0, ncs[d], noe[d], nwe[d], oe[d], ack[d]}, 32'h1C);
            check($sformatf("d%0d rst_nbe", d), nbe_of(d), d == 0 ? 32'hF : 32'h3);
            check($sformatf("d%0d rst_addr", d), addr_of(d), 32'h0);
            check($sformatf("d%0d rst_rdata", d), rdat[d], 32'h0);
        end
        check("d0 rst_sdo", sdo0, 32'h0);
        check("d1 rst_sdo", {16'b0, sdo1}, 32'h0);
        xfer(0, 1'b0, 20'h14, 32'h0, 4'hF);
        xfer(0, 1'b1, 20'h20, 32'hAABBCCDD, 4'b0011);
        xfer(0, 1'b0, 20'h20, 32'h0, 4'hF);
        xfer(1, 1'b0, 20'h10, 32'h0, 4'hF);
        xfer(1, 1'b1, 20'h30, 32'h01020304, 4'b0011);
        xfer(1, 1'b0, 20'h30, 32'h0, 4'hF);
        xfer(1, 1'b1, 20'h34, 32'h05060708, 4'b0000);
        xfer(1, 1'b0, 20'h34, 32'h0, 4'b1001);
        @(negedge clk);
        adr[1] = 20'h40; wdat[1] = 32'hCAFEF00D; sel[1] = 4'hF; we[1] = 1'b1; cyc[1] = 1'b1; stb[1] = 1'b1;
        acks = 0; starts = 0; nwe_c = 0; pn = 1'b1; pa = '1;
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            if (!ncs[1] && (pn || addr_of(1) != pa)) starts++;
            if (!nwe[1]) nwe_c++;
            if (ack[1]) acks++;
            pn = ncs[1]; pa = addr_of(1);
            if (k == 2) begin cyc[1] = 1'b0; stb[1] = 1'b0; end
        end
        we[1] = 1'b0;
        check("d1 abort_acks", acks, 0);
        check("d1 abort_cycles", starts, 1);
        check("d1 abort_nwe_low", nwe_c, 2);
        refm[1][64] = 8'hCA; refm[1][65] = 8'hFE;
        xfer(1, 1'b0, 20'h40, 32'h0, 4'hF);
        @(negedge clk);
        adr[0] = 20'h80; wdat[0] = 32'h5A5A5A5A; sel[0] = 4'hF; we[0] = 1'b1; cyc[0] = 1'b1; stb[0] = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1;
        check("d0 async_rst_strobes", {27'b0, ncs[0], noe[0], nwe[0], oe[0], ack[0]}, 32'h1C);
        check("d0 async_rst_nbe", nbe_of(0), 32'hF);
        cyc[0] = 1'b0; stb[0] = 1'b0; we[0] = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        for (int n = 0; n < 80; n++)
            xfer(n % 2, 1'($urandom), 20'($urandom_range(0, 1023)), $urandom, 4'($urandom));
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/sram_ctrl.md
# sram_ctrl

Parametrised Wishbone-slave controller for external asynchronous SRAM, sitting between the m68k Wishbone bus and the board SRAM pins. Unlike the plain combinational SRAM adapter, it registers all SRAM strobes, provides separate read/write wait-state counts and an address-setup phase, and supports 32- or 16-bit SRAM by splitting one 32-bit Wishbone access into two half-word SRAM cycles. It is glitch-free on `nWE` and never truncates an SRAM cycle once started.

## Interface
- `AWIDTH`, 20: Wishbone byte-address width.
- `SRAM_DW`, 32: SRAM data width, 32 or 16.
- `RD_WAIT`, 1: extra `nOE` cycles per read, 0..15.
- `WR_WAIT`, 1: extra `nWE` cycles per write, 0..15.
- Derived `SAW = AWIDTH - log2(SRAM_DW/8)`: SRAM word-address width.

Ports:
- `wb_clk_i`  in  1: the only clock.
- `wb_rst_i`  in  1: reset, asynchronous, active-high.
- `wb_adr_i`  in  AWIDTH: byte address; bits [1:0] are ignored.
- `wb_dat_i`  in  32: write data.
- `wb_dat_o`  out  32: read data. Valid while `wb_ack_o` is high.
- `wb_sel_i`  in  4: byte lanes; [3] is the MSB lane (big-endian).
- `wb_we_i`, `wb_cyc_i`, `wb_stb_i`  in  1 each: standard Wishbone classic.
- `wb_ack_o`  out  1: registered one-cycle acknowledge.
- `sram_dat_i`  in  SRAM_DW: SRAM read data.
- `sram_dat_o`  out  SRAM_DW: SRAM write data.
- `sram_dat_oe_o`  out  1: pad output enable; 1 = drive `sram_dat_o`.
- `sram_addr_o`  out  SAW: SRAM word address.
- `sram_nbe_o`  out  SRAM_DW/8: active-low byte enables.
- `sram_ncs_o`, `sram_noe_o`, `sram_nwe_o`  out  1 each: active-low strobes.

## Operation
- **Registered outputs.** All SRAM outputs and `wb_ack_o` come straight from flops.
- **Reset values.** `ncs`, `noe`, `nwe` and all of `nbe` are 1. `dat_oe`, `ack`, `addr`, `sram_dat_o` and `wb_dat_o` are 0.
- **FSM states.** IDLE, SETUP, ACCESS, HOLD (only with the macro), ACK.
- **IDLE.** On `cyc & stb & ~ack`, latch address, data, sel and we, pick the first half, and go to SETUP.
- **SETUP (1 cycle).**
  - `ncs` = 0, with address and `nbe` valid.
  - Writes: `dat_oe` = 1 and write data is driven.
  - Reads: `noe` = 0.
- **ACCESS (WAIT+1 cycles, WAIT = RD_WAIT or WR_WAIT).**
  - Writes: `nwe` = 0.
  - Reads: `noe` stays 0; `sram_dat_i` lanes are captured on the last cycle.
- **After ACCESS.**
  - If a second half is pending, go to SETUP.
  - Otherwise go to ACK.
  - Writes go through HOLD first when the macro is enabled.
- **ACK (1 cycle).** `wb_ack_o` = 1 and all strobes are inactive. Next state is IDLE.
- **SRAM_DW = 32.** One SRAM cycle; `nbe = ~wb_sel_i`; `addr = wb_adr_i[AWIDTH-1:2]`.
- **SRAM_DW = 16.**
  - Upper half (sel[3:2], data[31:16]) goes to `{adr[AWIDTH-1:2],0}`.
  - Lower half (sel[1:0], data[15:0]) goes to `{adr[AWIDTH-1:2],1}`.
  - A half whose sel bits are both 0 is skipped.
  - If sel is all zero, one upper-half cycle runs with `nbe` all 1.
- **Read data.** Unselected lanes of `wb_dat_o` are 0, never X.
- **`wb_cyc_i` dropped mid-transfer.** The current SRAM half completes in full, the remaining half is skipped, no ack is issued, and the FSM returns to IDLE.
- **`wb_stb_i` changes after acceptance** are ignored.
- **Asynchronous reset mid-cycle.** Outputs go immediately to their reset values and the FSM goes to IDLE.

## Timing
- **Reference point.** Edge 0 is the clock edge that samples the request in IDLE.
- **32-bit read.** `wb_ack_o` is high in cycle RD_WAIT+3; `noe` is low for RD_WAIT+2 cycles.
- **32-bit write.** `wb_ack_o` is high in cycle WR_WAIT+3, or WR_WAIT+4 with HOLD; `nwe` is low for exactly WR_WAIT+1 cycles.
- **16-bit, both halves.** Latency is 2·(WAIT+2)+1 cycles, or 2·(WAIT+3)+1 for writes with HOLD.
- **Strobe ordering.** `nwe` falls at least 1 cycle after the address and `ncs` settle, and never toggles within a half.
- **Back-to-back requests.** Earliest next acceptance is the cycle after ACK, because IDLE ignores `stb` while `ack` is high.
- **Wait counter.** 4 bits, loaded with WAIT and counting down to 0. WAIT = 0 gives a 1-cycle ACCESS.

## Configuration
- **Macro:** `SRAM_CTRL_WE_HOLD_EN`.
- **Defined:** writes insert HOLD after ACCESS: 1 cycle with `nwe` = 1 while `ncs` = 0, `dat_oe` = 1 and address/data are held. This gives data-hold margin after the `nWE` rising edge.
- **Undefined:** there is no HOLD state. `nwe` and `ncs` rise on the same edge, and `dat_oe` drops on that edge too.

## Structure
- **`sram_ctrl_pkg`:**
  - state enum `sram_state_t` (IDLE, SETUP, ACCESS, HOLD, ACK);
  - `SRAM_WAIT_W = 4`;
  - function `sram_saw(AWIDTH, SRAM_DW)`.
- **Sub-module `sram_wait_cnt`:** loadable 4-bit down-counter with `load`, `val` and `zero` outputs, used by ACCESS.

## Test plan
- **32-bit read.** SRAM_DW=32, RD_WAIT=1, SRAM model holds 0x11223344 at word 5. Read 0x14 with sel=4'b1111 -> ack in cycle 4, `wb_dat_o`=0x11223344, `noe` low 3 cycles.
- **32-bit partial write.** WR_WAIT=2 without the macro. Write 0xAABBCCDD to 0x20 with sel=4'b0011 -> `nwe` low 3 cycles, `nbe`=4'b1100, memory lanes [15:0]=0xCCDD, ack in cycle 5.
- **16-bit split read.** SRAM_DW=16, RD_WAIT=0, halfwords 0x1234 at addr 8 and 0x5678 at addr 9. Read 0x10 with sel=1111 -> two SRAM cycles at 8 then 9, `wb_dat_o`=0x12345678, ack in cycle 5.
- **Skipped half.** SRAM_DW=16. Write with sel=4'b0011 -> only one SRAM cycle, at the odd address; the upper half is skipped.
- **`SRAM_CTRL_WE_HOLD_EN` defined.** Write -> `nwe` rises one cycle before `ncs`; `dat_oe` stays 1 through HOLD; ack is delayed by 1 cycle.
- **Abort and reset.**
  - Drop `wb_cyc_i` during ACCESS of the first half of a 16-bit write -> that half completes, no second half, no ack.
  - Assert `wb_rst_i` mid-ACCESS -> strobes are 1 and `dat_oe` is 0 before the next clock edge.
